// File: rtl/random_share_arbiter.sv
// Shares one random-word generator among several consumers: owns its reset, seed and
// clock-enable, discards a warm-up run after each reseed, then serves requesters round-robin.
module random_share_arbiter #(
    parameter int          Width       = 8,
    parameter int          Requesters  = 4,
    parameter int          WarmUp      = 16,
    parameter int unsigned DefaultSeed = 32'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [Width-1:0]      seed,
    input  logic [Requesters-1:0] req,
    output logic [Requesters-1:0] grant,
    output logic                  valid,
    output logic [Width-1:0]      data,
    output logic                  busy,
    output logic                  gen_rst,
    output logic [Width-1:0]      gen_seed,
    output logic                  gen_ce,
    input  logic [Width-1:0]      gen_random
);

    localparam int PW = $clog2(Requesters);
    localparam int CW = $clog2(WarmUp + 1);

    typedef enum logic [2:0] {
        S_SEED,
        S_WARMUP,
        S_READY,
        S_STEP,
        S_DELIVER
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   winner_reg, winner_next;
    logic [Width-1:0] seed_reg, seed_next;

    logic            any_found;
    logic [PW-1:0]   pick;

    // Round-robin search: first set request at or after ptr, wrapping modulo Requesters.
    always_comb begin
        int idx;
        any_found = 1'b0;
        pick      = ptr_reg;
        idx       = 0;
        for (int i = 0; i < Requesters; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= Requesters) begin
                idx = idx - Requesters;
            end
            if (!any_found && req[idx]) begin
                any_found = 1'b1;
                pick      = PW'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        seed_next   = seed_reg;
        case (state_reg)
            S_SEED: begin
                state_next = S_WARMUP;
                cnt_next   = CW'(WarmUp);
            end
            S_WARMUP: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (any_found) begin
                    winner_next = pick;
                    state_next  = S_STEP;
                end
            end
            S_STEP: begin
                state_next = S_DELIVER;
            end
            S_DELIVER: begin
                ptr_next   = (winner_reg == PW'(Requesters - 1)) ? '0 : winner_reg + PW'(1);
                state_next = S_READY;
            end
            default: begin
                state_next = S_SEED;
            end
        endcase
        // A reseed overrides everything; the pointer keeps its place so fairness survives.
        if (seed_load) begin
            state_next = S_SEED;
            seed_next  = seed;
            ptr_next   = ptr_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_SEED;
            cnt_reg    <= CW'(WarmUp);
            ptr_reg    <= '0;
            winner_reg <= '0;
            seed_reg   <= Width'(DefaultSeed);
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            winner_reg <= winner_next;
            seed_reg   <= seed_next;
        end
    end

    assign gen_rst  = (state_reg == S_SEED);
    assign busy     = (state_reg == S_SEED) || (state_reg == S_WARMUP);
    assign gen_ce   = (state_reg == S_WARMUP) || (state_reg == S_STEP);
    assign valid    = (state_reg == S_DELIVER);
    assign gen_seed = seed_reg;
    assign data     = valid ? gen_random : '0;

    generate
        for (genvar gi = 0; gi < Requesters; gi++) begin : g_grant
            assign grant[gi] = valid && (winner_reg == PW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_random_share_arbiter.sv
// Randomized scoreboard bench for random_share_arbiter with an external generator and a
// step-counting reference model of the delivered word stream.
module tb_random_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       seed_load;
    logic [7:0] seed;
    logic [3:0] req;
    logic [3:0] grant;
    logic       valid;
    logic [7:0] data;
    logic       busy;
    logic       gen_rst;
    logic [7:0] gen_seed;
    logic       gen_ce;
    logic [7:0] gen_random;

    random_share_arbiter #(
        .Width(8), .Requesters(4), .WarmUp(16), .DefaultSeed(32'h5A)
    ) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .grant(grant), .valid(valid), .data(data), .busy(busy), .gen_rst(gen_rst),
        .gen_seed(gen_seed), .gen_ce(gen_ce), .gen_random(gen_random)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lca(input logic [7:0] x);
        return x * 8'd5 + 8'd3;
    endfunction

    // Stand-in generator driven by the arbiter's control strobes
    logic [7:0] gen_val = 8'h00;
    always @(posedge clk) begin
        if (gen_rst) gen_val <= gen_seed;
        else if (gen_ce) gen_val <= lca(gen_val);
    end
    assign gen_random = gen_val;

    typedef struct { logic [3:0] g; logic [7:0] d; } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int stray = 0;
    logic [7:0] model_gen;
    int model_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reseed(input logic [7:0] s);
        model_gen = s;
        repeat (16) model_gen = lca(model_gen);
        $display("model reseed %02h -> ready value %02h", s, model_gen);
    endtask

    function automatic int pick_winner(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(model_ptr + i) % 4]) return (model_ptr + i) % 4;
        end
        return -1;
    endfunction

    // Monitor: pops one expectation per delivered word
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("deliver grant=%b data=%02h (exp %b %02h)", grant, data, e.g, e.d);
                    check("grant", 32'(grant), 32'(e.g));
                    check("data", 32'(data), 32'(e.d));
                    check("ce_in_deliver", 32'(gen_ce), 32'd0);
                end
            end else if (grant != 4'd0 || data != 8'd0) begin
                stray++;
            end
        end
    end

    // Drive one request pattern, predict the winner, and wait for its delivery
    task automatic issue(input logic [3:0] r, input int exp_lat);
        int w;
        int lat;
        exp_t e;
        req = r;
        w = pick_winner(r);
        model_gen = lca(model_gen);
        e.g = 4'(1 << w);
        e.d = model_gen;
        exp_q.push_back(e);
        model_ptr = (w + 1) % 4;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid && lat < 20);
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    // Entered at a negedge in SEED; returns at the first READY negedge
    task automatic check_warmup(input logic [7:0] exp_seed);
        int n;
        int bad;
        check("seed_gen_rst", 32'(gen_rst), 32'd1);
        check("seed_busy", 32'(busy), 32'd1);
        check("seed_gen_seed", 32'(gen_seed), 32'(exp_seed));
        n = 0;
        bad = 0;
        @(negedge clk);
        while (gen_ce && busy && n < 40) begin
            n++;
            if (gen_seed !== exp_seed || gen_rst) bad++;
            @(negedge clk);
        end
        $display("warm-up steps %0d seed %02h", n, gen_seed);
        check("warmup_steps", 32'(n), 32'd16);
        check("warmup_seed", 32'(bad), 32'd0);
        check("ready_busy", 32'(busy), 32'd0);
        check("ready_ce", 32'(gen_ce), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_cnt;
        logic [3:0] rr;
        rst = 1'b1; seed_load = 1'b0; seed = 8'h00; req = 4'd0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        check("rst_gen_rst", 32'(gen_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ce", 32'(gen_ce), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_seed", 32'(gen_seed), 32'h5A);
        rst = 1'b0;
        check_warmup(8'h5A);
        model_reseed(8'h5A);

        // Round-robin with all requesting
        for (int k = 0; k < 5; k++) issue(4'b1111, (k == 0) ? 2 : 3);
        // Sparse and wrapping requests
        issue(4'b1001, 3);
        issue(4'b1001, 3);
        issue(4'b0100, 3);
        req = 4'd0;
        // Randomized request patterns
        for (int k = 0; k < 12; k++) begin
            rr = 4'($urandom_range(1, 15));
            issue(rr, 3);
        end
        req = 4'd0;

        // Reseed while a request sits in STEP
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        check("step_ce", 32'(gen_ce), 32'd1);
        check("step_valid", 32'(valid), 32'd0);
        seed_load = 1'b1; seed = 8'hC3;
        @(negedge clk);
        seed_load = 1'b0; req = 4'd0;
        check_warmup(8'hC3);
        model_reseed(8'hC3);
        issue(4'b1111, 2);
        issue(4'b1111, 3);
        req = 4'd0;

        // Asynchronous reset at warm-up count 7
        @(negedge clk);
        seed_load = 1'b1; seed = 8'h77;
        @(negedge clk);
        seed_load = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_ce", 32'(gen_ce), 32'd1);
        check("pre_rst_seed", 32'(gen_seed), 32'h77);
        #2 rst = 1'b1;
        #1;
        check("arst_gen_rst", 32'(gen_rst), 32'd1);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_ce", 32'(gen_ce), 32'd0);
        check("arst_seed", 32'(gen_seed), 32'h5A);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        model_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        check_warmup(8'h5A);
        model_reseed(8'h5A);

        // Long idle must not step the generator
        ce_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (gen_ce) ce_cnt++;
        end
        check("idle_ce", 32'(ce_cnt), 32'd0);
        issue(4'b0001, 2);
        req = 4'd0;

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("stray_outputs", 32'(stray), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
